axi_regfile_slave: RTL and testbench

Parametrised AXI-style register-file slave, next generation of the team's single-channel AXI slave. It serves the I2C bridge control/status space with configurable data width, address width and depth. Read and write channels are independent and run concurrently. Adds byte strobes, FIXED/INCR/WRAP bursts and SLVERR reporting. Two addresses are mapped to live hardware inputs, status and received data.

---
 rtl/axi_regfile_pkg.sv | 36 +++
 rtl/axi_burst_addr.sv | 75 +++++++
 rtl/axi_regfile_slave.sv | 172 +++++++++++++++++
 tb/tb_axi_regfile_slave.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_regfile_pkg.sv
// Shared types for the AXI register-file slave.
// Optional WRAP burst support: define AXI_REGFILE_WRAP_EN.
package axi_regfile_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  // mask selects the bits allowed to count; all-ones gives plain INCR
  function automatic logic [31:0] burst_next_addr(
    input logic [31:0] addr,
    input logic [1:0]  burst,
    input logic [31:0] mask
  );
    if (burst == BURST_FIXED) return addr;
    return (addr & ~mask) | ((addr + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Per-channel burst address and beat-count tracker.
// WRAP boundary logic present only with AXI_REGFILE_WRAP_EN.
module axi_burst_addr
  import axi_regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [3:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              burst_err
);

  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        cnt_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] nxt;
  logic              start_err;

`ifdef AXI_REGFILE_WRAP_EN
  logic [ADDR_W-1:0] mask_q;
  logic [ADDR_W-1:0] start_mask;
  logic              wrap;
  logic              wrap_ok;

  assign wrap       = burst == BURST_WRAP;
  assign wrap_ok    = len inside {4'd1, 4'd3, 4'd7, 4'd15};
  assign start_mask = (wrap && wrap_ok) ? ADDR_W'(len) : '1;
  assign start_err  = (burst == BURST_RSVD) || (wrap && !wrap_ok);
  assign mask       = mask_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      mask_q <= '1;
    end else if (start) begin
      mask_q <= start_mask;
    end
  end
`else
  assign start_err = burst == BURST_RSVD;
  assign mask      = '1;
`endif

  assign nxt = ADDR_W'(burst_next_addr(32'(addr_q), burst_q, 32'(mask)));

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else if (start) begin
      addr_q  <= start_addr;
      cnt_q   <= {1'b0, len} + 5'd1;
      burst_q <= burst;
      err_q   <= start_err;
    end else if (step) begin
      addr_q <= nxt;
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  assign addr      = addr_q;
  assign last      = cnt_q == 5'd1;
  assign burst_err = err_q;

endmodule

// File: rtl/axi_regfile_slave.sv
// AXI-style register-file slave with independent read/write channels.
// Define AXI_REGFILE_WRAP_EN to enable aligned WRAP bursts.
module axi_regfile_slave
  import axi_regfile_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int STATUS_ADDR = 3,
  parameter int RXDATA_ADDR = 4
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arsize,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awsize,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic [DATA_W-1:0]   status_in,
  input  logic [DATA_W-1:0]   data_rx_in
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] RXDATA_A = ADDR_W'(RXDATA_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);

  rd_state_e rstate;
  wr_state_e wstate;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr;
  logic r_last, r_berr, r_oob;
  logic w_last, w_berr, w_oob, w_bad, w_err;
  logic werr_q;
  logic ar_hs, aw_hs, r_beat, w_beat;
  logic size_unused;

  assign size_unused = ^{arsize, awsize};

  assign arready = rstate == R_IDLE;
  assign rvalid  = rstate == R_DATA;
  assign awready = wstate == W_IDLE;
  assign wready  = wstate == W_DATA;
  assign bvalid  = wstate == W_RESP;

  assign ar_hs  = arvalid & arready;
  assign r_beat = rvalid & rready;
  assign aw_hs  = awvalid & awready;
  assign w_beat = wvalid & wready;

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
    .clk        (clk),
    .res_n      (res_n),
    .start      (ar_hs),
    .step       (r_beat),
    .start_addr (araddr),
    .len        (arlen),
    .burst      (arburst),
    .addr       (r_addr),
    .last       (r_last),
    .burst_err  (r_berr)
  );

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
    .clk        (clk),
    .res_n      (res_n),
    .start      (aw_hs),
    .step       (w_beat),
    .start_addr (awaddr),
    .len        (awlen),
    .burst      (awburst),
    .addr       (w_addr),
    .last       (w_last),
    .burst_err  (w_berr)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rstate <= R_IDLE;
    end else begin
      unique case (rstate)
        R_IDLE: if (ar_hs) rstate <= R_DATA;
        R_DATA: if (r_beat && r_last) rstate <= R_IDLE;
      endcase
    end
  end

  assign r_oob = {1'b0, r_addr} >= DEPTH_A;

  // Read data bypasses the write port, so a same-cycle write is not seen
  always_comb begin
    rdata = '0;
    rresp = RESP_OKAY;
    if (rvalid) begin
      unique case (1'b1)
        r_oob:                        rresp = RESP_SLVERR;
        !r_oob && r_addr == STATUS_A: rdata = status_in;
        !r_oob && r_addr == RXDATA_A: rdata = data_rx_in;
        default:                      rdata = mem[r_addr];
      endcase
      if (r_berr) rresp = RESP_SLVERR;
    end
  end

  assign rlast = rvalid & r_last;

  assign w_oob = {1'b0, w_addr} >= DEPTH_A;
  assign w_bad = w_oob | (w_addr == STATUS_A) | (w_addr == RXDATA_A);
  assign w_err = w_bad | (wlast != w_last) | w_berr;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wstate <= W_IDLE;
      werr_q <= 1'b0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            wstate <= W_DATA;
            werr_q <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            werr_q <= werr_q | w_err;
            if (w_last) wstate <= W_RESP;
          end
        end
        W_RESP: if (bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign bresp = (bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem[0] <= '1;
      mem[1] <= {(DATA_W/4){4'h1}};
    end else if (w_beat && !w_bad) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[w_addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_regfile_slave.sv
// Scoreboard bench for axi_regfile_slave (DEPTH=31 instance).
module tb_axi_regfile_slave;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 31;
  localparam int TMO   = 50;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [AW-1:0] araddr = '0;
  logic [3:0]    arlen = '0;
  logic [1:0]    arburst = '0;
  logic [2:0]    arsize = 3'd1;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [AW-1:0] awaddr = '0;
  logic [3:0]    awlen = '0;
  logic [1:0]    awburst = '0;
  logic [2:0]    awsize = 3'd1;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [1:0]    bresp;
  logic [DW-1:0] status_in = '0;
  logic [DW-1:0] data_rx_in = '0;

  axi_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .STATUS_ADDR(3), .RXDATA_ADDR(4)
  ) dut (
    .clk(clk), .res_n(res_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .status_in(status_in), .data_rx_in(data_rx_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  r;
    logic        l;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [15:0] model [32];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit wrap_legal(int burst, int len);
`ifdef AXI_REGFILE_WRAP_EN
    return burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit burst_bad(int burst, int len);
`ifdef AXI_REGFILE_WRAP_EN
    if (burst == 2 && !wrap_legal(burst, len)) return 1'b1;
`endif
    return burst == 3;
  endfunction

  function automatic int tb_next(int a, int burst, int len);
    int beats;
    int base;
    if (burst == 0) return a;
    if (wrap_legal(burst, len)) begin
      beats = len + 1;
      base  = a - (a % beats);
      return base + ((a + 1 - base) % beats);
    end
    return (a + 1) % 32;
  endfunction

  function automatic bit wr_drop(int a);
    return a >= DEPTH || a == 3 || a == 4;
  endfunction

  function automatic logic [15:0] rd_val(int a);
    if (a >= DEPTH) return 16'h0000;
    if (a == 3) return status_in;
    if (a == 4) return data_rx_in;
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[0] = 16'hFFFF;
    model[1] = 16'h1111;
  endtask

  task automatic do_read(input int a0, input int len, input int burst);
    int    a;
    int    t;
    bit    be;
    rexp_t e;
    a  = a0;
    be = burst_bad(burst, len);
    for (int i = 0; i <= len; i++) begin
      e.d = rd_val(a);
      e.r = (a >= DEPTH || be) ? 2'b10 : 2'b00;
      e.l = (i == len);
      rq.push_back(e);
      a = tb_next(a, burst, len);
    end
    araddr  = a0[4:0];
    arlen   = len[3:0];
    arburst = burst[1:0];
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin
      @(posedge clk); #1; t++;
    end
    if (t == TMO) begin
      n_cmp++; n_bad++;
      $display("FAIL ar_handshake: arready=%b required 1", arready);
      arvalid = 1'b0;
      rq.delete();
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!rvalid && t < TMO) begin
        @(posedge clk); #1; t++;
      end
      if (t == TMO) begin
        n_cmp++; n_bad++;
        $display("FAIL r_timeout: rvalid=%b required 1", rvalid);
        rready = 1'b0;
        rq.delete();
        return;
      end
      e = rq.pop_front();
      n_cmp++;
      if ({rdata, rresp, rlast} !== {e.d, e.r, e.l}) begin
        n_bad++;
        $display("FAIL rbeat @%0d #%0d: got %h/%b/%b need %h/%b/%b",
                 a0, i, rdata, rresp, rlast, e.d, e.r, e.l);
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic do_write(input int a0, input int len, input int burst,
                          input logic [15:0] d0, input logic [1:0] strb,
                          input int bad_last);
    int         a;
    int         t;
    bit         err;
    logic       wl;
    logic [1:0] eb;
    a   = a0;
    err = burst_bad(burst, len);
    awaddr  = a0[4:0];
    awlen   = len[3:0];
    awburst = burst[1:0];
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < TMO) begin
      @(posedge clk); #1; t++;
    end
    if (t == TMO) begin
      n_cmp++; n_bad++;
      $display("FAIL aw_handshake: awready=%b required 1", awready);
      awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wl = (bad_last < 0) ? (i == len) : (i == bad_last);
      if (wl != (i == len)) err = 1'b1;
      wvalid = 1'b1;
      wdata  = d0 + 16'(i);
      wstrb  = strb;
      wlast  = wl;
      t = 0;
      while (!wready && t < TMO) begin
        @(posedge clk); #1; t++;
      end
      if (t == TMO) begin
        n_cmp++; n_bad++;
        $display("FAIL w_timeout: wready=%b required 1", wready);
        wvalid = 1'b0;
        return;
      end
      if (wr_drop(a)) err = 1'b1;
      else begin
        if (strb[0]) model[a][7:0]  = wdata[7:0];
        if (strb[1]) model[a][15:8] = wdata[15:8];
      end
      a = tb_next(a, burst, len);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bq.push_back(err ? 2'b10 : 2'b00);
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < TMO) begin
      @(posedge clk); #1; t++;
    end
    eb = bq.pop_front();
    n_cmp++;
    if (t == TMO || bresp !== eb) begin
      n_bad++;
      $display("FAIL bresp @%0d: got %b valid %b need %b", a0, bresp, bvalid, eb);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({arready, awready, rvalid, wready, bvalid, rlast} !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b need 110000",
               {arready, awready, rvalid, wready, bvalid, rlast});
    end
    n_cmp++;
    if ({rdata, rresp, bresp} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%b/%b need 0", rdata, rresp, bresp);
    end
    @(posedge clk); @(posedge clk); #1;
    res_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_incr_read();
    do_read(0, 1, 1);
    n_cmp++;
    if (arready !== 1'b1) begin
      n_bad++;
      $display("FAIL arready_after: got %b need 1", arready);
    end
  endtask

  task automatic test_strobe();
    do_write(6, 0, 1, 16'hABCD, 2'b01, -1);
    do_read(6, 0, 1);
  endtask

  task automatic test_mapped();
    status_in  = 16'h5A5A;
    data_rx_in = 16'h0042;
    do_write(3, 0, 1, 16'h1234, 2'b11, -1);
    do_read(3, 1, 1);
  endtask

  task automatic test_addr_wrap();
    do_write(30, 3, 1, 16'h0001, 2'b11, -1);
    do_read(30, 3, 1);
  endtask

  task automatic test_burst_types();
    do_write(4, 5, 1, 16'h0A00, 2'b11, -1);
    do_read(6, 3, 2);
    do_read(6, 2, 2);
    do_write(8, 2, 0, 16'h7700, 2'b11, -1);
    do_read(7, 2, 0);
    do_read(8, 0, 1);
    do_read(0, 1, 3);
    do_write(20, 1, 3, 16'h2000, 2'b10, -1);
    do_read(20, 1, 1);
  endtask

  task automatic test_wlast();
    do_write(10, 1, 1, 16'hC000, 2'b11, 0);
    do_read(10, 1, 1);
  endtask

  task automatic test_concurrent();
    do_write(12, 0, 1, 16'h1357, 2'b11, -1);
    araddr = 5'd12; arlen = 4'd0; arburst = 2'b01; arvalid = 1'b1;
    awaddr = 5'd12; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
    n_cmp++;
    if ({arready, awready} !== 2'b11) begin
      n_bad++;
      $display("FAIL conc_ready: got %b need 11", {arready, awready});
    end
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    wvalid = 1'b1; wdata = 16'h2468; wstrb = 2'b11; wlast = 1'b1;
    rready = 1'b1;
    n_cmp++;
    if ({rvalid, wready, rdata} !== {2'b11, 16'h1357}) begin
      n_bad++;
      $display("FAIL conc_old: got %b%b/%h need 11/1357", rvalid, wready, rdata);
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    model[12] = 16'h2468;
    bready = 1'b1;
    n_cmp++;
    if ({bvalid, bresp} !== 3'b100) begin
      n_bad++;
      $display("FAIL conc_b: got %b/%b need 1/00", bvalid, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    do_read(12, 0, 1);
  endtask

  task automatic test_reset_mid_burst();
    araddr = 5'd12; arlen = 4'd7; arburst = 2'b00; arvalid = 1'b1;
    awaddr = 5'd13; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    rready = 1'b1;
    wvalid = 1'b1; wdata = 16'hBEEF; wstrb = 2'b11; wlast = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    n_cmp++;
    if ({rvalid, bvalid} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_active: got %b need 11", {rvalid, bvalid});
    end
    #2;
    res_n = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid, bvalid, wready, arready, awready} !== 5'b00011) begin
      n_bad++;
      $display("FAIL mid_reset: got %b need 00011",
               {rvalid, bvalid, wready, arready, awready});
    end
    rready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    res_n = 1'b1;
    @(posedge clk); #1;
    do_read(0, 1, 1);
    do_read(6, 0, 1);
    do_read(12, 1, 1);
  endtask

  initial begin
    test_reset();
    test_incr_read();
    test_strobe();
    test_mapped();
    test_addr_wrap();
    test_burst_types();
    test_wlast();
    test_concurrent();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
